// File: rtl/program_counter.sv
// program_counter: Hack CPU program counter. Each clock edge it loads a jump target, increments, or holds; reset is asynchronous.
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next;
    // next PC: load beats increment beats hold; increment wraps modulo 2**WIDTH
    always_comb w_next = load ? in : inc ? r_pc + WIDTH'(1) : r_pc;
    // PC register; asynchronous reset discards any load/inc pending in the same cycle
    always_ff @(posedge clk or posedge reset)
        if (reset) r_pc <= RESET_VALUE;
        else       r_pc <= w_next;
    assign out = r_pc;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed-vector check of the program counter priority, wrap and async reset
module tb_program_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic [15:0] out;
    int          n_checks = 0;
    int          n_pass = 0;

    program_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // drive 1 ns before the rising edge, check 1 ns after it
    task automatic step(input string tag, input logic r, input logic l, input logic i,
                        input logic [15:0] d, input logic [15:0] exp);
        @(negedge clk);
        #4;
        reset = r;
        load  = l;
        inc   = i;
        in    = d;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        step("preload", 1'b0, 1'b1, 1'b0, 16'h5555, 16'h5555);
        #2;
        reset = 1'b1;
        load  = 1'b0;
        in    = 16'h1234;
        #1;
        check("async_reset", out, 16'h0000);
        step("reset_edge1", 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        step("reset_edge2", 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        step("inc1", 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0001);
        step("inc2", 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0002);
        step("inc3", 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0003);
        step("hold3", 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0003);
        step("load_beats_inc", 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100);
        step("inc_after_load", 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0101);
        step("load_ffff", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        step("wrap", 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        step("load_0101", 1'b0, 1'b1, 1'b0, 16'h0101, 16'h0101);
        step("reset_beats_all", 1'b1, 1'b1, 1'b1, 16'hABCD, 16'h0000);
        step("inc_after_reset", 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0001);
        step("hold_a", 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0001);
        step("hold_b", 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0001);
        step("hold_c", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        step("hold_d", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001);
        #2;
        load = 1'b1;
        inc  = 1'b1;
        in   = 16'h7777;
        #2;
        check("no_effect_between_edges", out, 16'h0001);
        step("load_7777", 1'b0, 1'b1, 1'b1, 16'h7777, 16'h7777);
        step("inc_7778", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h7778);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
